instr_fetch_unit: RTL and testbench

- Instruction fetch front end for the single-cycle MIPS datapath.
- Owns the fetch PC and issues word reads to instruction memory through a req/ack handshake.
- Buffers returned words in a small FIFO and presents them, with their opcode field, to the opcode decoder and datapath.
- Takes the decoder's Jump/Branch outputs and the ALU Zero flag back in, and redirects fetch on a taken beq or a j.

---
 rtl/instr_fetch_unit.sv | 238 +++++++++++++++++++++++
 tb/tb_instr_fetch_unit.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// Instruction fetch front end: owns the fetch PC, issues req/ack word reads and buffers
// returned words in a small FIFO. Define IFU_PERF_CNT_EN to add flush/drop counters.

module instr_fetch_unit #(
  parameter logic [31:0] PC_RESET   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [5:0]  opcode,
  output logic [31:0] pc_plus4,
  input  logic        instr_ready,
  input  logic        Jump,
  input  logic        Branch,
  input  logic        Zero
`ifdef IFU_PERF_CNT_EN
  ,
  output logic [15:0] flush_count,
  output logic [15:0] drop_count
`endif
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DROP = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [31:0]       fetch_pc_q, fetch_pc_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [31:0]       fifo_instr_q [FIFO_DEPTH];
  logic [31:0]       fifo_instr_d [FIFO_DEPTH];
  logic [31:0]       fifo_pc4_q [FIFO_DEPTH];
  logic [31:0]       fifo_pc4_d [FIFO_DEPTH];
  logic              imem_req_q, imem_req_d;
  logic [31:0]       imem_addr_q, imem_addr_d;
  logic              instr_valid_q, instr_valid_d;
  logic [31:0]       instr_q, instr_d;
  logic [31:0]       pc_plus4_q, pc_plus4_d;

  logic              consume_s;
  logic              redirect_s;
  logic              ack_s;
  logic              push_s;
  logic [31:0]       jump_tgt_s;
  logic [31:0]       br_tgt_s;
  logic [31:0]       target_s;
  logic [CNT_W-1:0]  occ_pop_s;

  // Redirect decode for the head instruction and handshake qualification
  always_comb begin
    consume_s  = instr_valid_q & instr_ready;
    jump_tgt_s = {pc_plus4_q[31:28], instr_q[25:0], 2'b00};
    br_tgt_s   = pc_plus4_q + {{14{instr_q[15]}}, instr_q[15:0], 2'b00};
    redirect_s = consume_s & (Jump | (Branch & Zero));
    if (Jump) begin
      target_s = jump_tgt_s;
    end else begin
      target_s = br_tgt_s;
    end
    ack_s  = imem_ack & imem_req_q;
    push_s = ack_s & (state_q == REQ) & ~redirect_s;
  end

  // FIFO bookkeeping and next head presentation
  always_comb begin
    occ_pop_s    = count_q - CNT_W'(consume_s);
    fifo_instr_d = fifo_instr_q;
    fifo_pc4_d   = fifo_pc4_q;
    if (push_s) begin
      fifo_instr_d[wr_ptr_q] = imem_rdata;
      fifo_pc4_d[wr_ptr_q]   = fetch_pc_q + 32'd4;
    end else begin
      fifo_instr_d = fifo_instr_q;
      fifo_pc4_d   = fifo_pc4_q;
    end
    // A redirect flushes everything, including a word arriving this cycle
    if (redirect_s) begin
      count_d  = {CNT_W{1'b0}};
      rd_ptr_d = {PTR_W{1'b0}};
      wr_ptr_d = {PTR_W{1'b0}};
    end else begin
      count_d  = occ_pop_s + CNT_W'(push_s);
      rd_ptr_d = rd_ptr_q + PTR_W'(consume_s);
      wr_ptr_d = wr_ptr_q + PTR_W'(push_s);
    end
    if (count_d == {CNT_W{1'b0}}) begin
      instr_valid_d = 1'b0;
      instr_d       = instr_q;
      pc_plus4_d    = pc_plus4_q;
    end else if (occ_pop_s == {CNT_W{1'b0}}) begin
      instr_valid_d = 1'b1;
      instr_d       = imem_rdata;
      pc_plus4_d    = fetch_pc_q + 32'd4;
    end else begin
      instr_valid_d = 1'b1;
      instr_d       = fifo_instr_q[rd_ptr_d];
      pc_plus4_d    = fifo_pc4_q[rd_ptr_d];
    end
  end

  // Fetch PC and request FSM next state
  always_comb begin
    if (redirect_s) begin
      fetch_pc_d = target_s;
    end else if (push_s) begin
      fetch_pc_d = fetch_pc_q + 32'd4;
    end else begin
      fetch_pc_d = fetch_pc_q;
    end
    case (state_q)
      IDLE: begin
        if (occ_pop_s < DEPTH_C) begin
          state_d = REQ;
        end else begin
          state_d = IDLE;
        end
      end
      REQ: begin
        if (ack_s) begin
          if (count_d < DEPTH_C) begin
            state_d = REQ;
          end else begin
            state_d = IDLE;
          end
        end else if (redirect_s) begin
          state_d = DROP;
        end else begin
          state_d = REQ;
        end
      end
      DROP: begin
        if (ack_s) begin
          state_d = REQ;
        end else begin
          state_d = DROP;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    imem_req_d = (state_d != IDLE);
    // An unacknowledged request keeps its address even after fetch_pc moves on
    if ((state_q != IDLE) && !ack_s) begin
      imem_addr_d = imem_addr_q;
    end else begin
      imem_addr_d = fetch_pc_d;
    end
  end

  // State and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      fetch_pc_q    <= PC_RESET;
      rd_ptr_q      <= {PTR_W{1'b0}};
      wr_ptr_q      <= {PTR_W{1'b0}};
      count_q       <= {CNT_W{1'b0}};
      fifo_instr_q  <= '{default: 32'd0};
      fifo_pc4_q    <= '{default: 32'd0};
      imem_req_q    <= 1'b0;
      imem_addr_q   <= PC_RESET;
      instr_valid_q <= 1'b0;
      instr_q       <= 32'd0;
      pc_plus4_q    <= 32'd0;
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      count_q       <= count_d;
      fifo_instr_q  <= fifo_instr_d;
      fifo_pc4_q    <= fifo_pc4_d;
      imem_req_q    <= imem_req_d;
      imem_addr_q   <= imem_addr_d;
      instr_valid_q <= instr_valid_d;
      instr_q       <= instr_d;
      pc_plus4_q    <= pc_plus4_d;
    end
  end

  assign imem_req    = imem_req_q;
  assign imem_addr   = imem_addr_q;
  assign instr_valid = instr_valid_q;
  assign instr       = instr_q;
  assign opcode      = instr_q[31:26];
  assign pc_plus4    = pc_plus4_q;

`ifdef IFU_PERF_CNT_EN
  logic        drop_s;
  logic [15:0] flush_count_q, flush_count_d;
  logic [15:0] drop_count_q, drop_count_d;

  // Saturating redirect and discarded-ack counters
  always_comb begin
    drop_s = ack_s & ((state_q == DROP) | redirect_s);
    if (redirect_s && (flush_count_q != 16'hFFFF)) begin
      flush_count_d = flush_count_q + 16'd1;
    end else begin
      flush_count_d = flush_count_q;
    end
    if (drop_s && (drop_count_q != 16'hFFFF)) begin
      drop_count_d = drop_count_q + 16'd1;
    end else begin
      drop_count_d = drop_count_q;
    end
  end

  // Counter registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flush_count_q <= 16'd0;
      drop_count_q  <= 16'd0;
    end else begin
      flush_count_q <= flush_count_d;
      drop_count_q  <= drop_count_d;
    end
  end

  assign flush_count = flush_count_q;
  assign drop_count  = drop_count_q;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: expected memory requests and consumed
// instructions are queued by directed tests and checked by a negedge monitor.

module tb_instr_fetch_unit;

  logic        clk;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic [31:0] instr;
  logic [5:0]  opcode;
  logic [31:0] pc_plus4;
  logic        instr_ready;
  logic        Jump;
  logic        Branch;
  logic        Zero;
`ifdef IFU_PERF_CNT_EN
  logic [15:0] flush_count;
  logic [15:0] drop_count;
`endif

  logic [31:0] mem [0:255];
  int          mem_wait;
  int          wait_cnt;
  logic        zero_val;
  int          tests_run;
  int          fails;
  logic [31:0] exp_req [$];
  logic [63:0] exp_out [$];

  instr_fetch_unit #(
    .PC_RESET   (32'h0000_0000),
    .FIFO_DEPTH (2)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .instr_valid (instr_valid),
    .instr       (instr),
    .opcode      (opcode),
    .pc_plus4    (pc_plus4),
    .instr_ready (instr_ready),
    .Jump        (Jump),
    .Branch      (Branch),
    .Zero        (Zero)
`ifdef IFU_PERF_CNT_EN
    ,
    .flush_count (flush_count),
    .drop_count  (drop_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: ack after mem_wait cycles of a held request (0 = same cycle)
  assign imem_ack   = imem_req && (wait_cnt >= mem_wait);
  assign imem_rdata = mem[imem_addr[9:2]];
  // Decoder model: j = opcode 2, beq = opcode 4
  assign Jump   = instr_valid && (opcode == 6'h02);
  assign Branch = instr_valid && (opcode == 6'h04);
  assign Zero   = zero_val;

  always @(posedge clk or posedge reset) begin
    if (reset) wait_cnt <= 0;
    else if (imem_req && !imem_ack) wait_cnt <= wait_cnt + 1;
    else wait_cnt <= 0;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  // Monitor: compare every accepted request and every consumed instruction
  always @(negedge clk) begin
    if (!reset) begin
      if (imem_req && imem_ack) begin
        if (exp_req.size() == 0) begin
          tests_run++;
          fails++;
          $display("FAIL unexpected_req: got addr %h, required no request", imem_addr);
        end else begin
          chk("req_addr", 64'(imem_addr), 64'(exp_req.pop_front()));
        end
      end
      if (instr_valid && instr_ready) begin
        if (exp_out.size() == 0) begin
          tests_run++;
          fails++;
          $display("FAIL unexpected_consume: got pc4/instr %h %h, required none", pc_plus4, instr);
        end else begin
          chk("consume_pc4_instr", {pc_plus4, instr}, exp_out.pop_front());
        end
      end
    end
  end

  task automatic init_mem();
    for (int i = 0; i < 256; i++) mem[i] = 32'h2000_0000 | 32'(i);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic exp_out_push(input int idx, input logic [31:0] pc4);
    exp_out.push_back({pc4, mem[idx]});
  endtask

  task automatic do_reset();
    reset = 1'b1;
    instr_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_imem_req", 64'(imem_req), 64'd0);
    chk("rst_imem_addr", 64'(imem_addr), 64'h0);
    chk("rst_instr_valid", 64'(instr_valid), 64'd0);
    chk("rst_instr", 64'(instr), 64'h0);
    chk("rst_opcode", 64'(opcode), 64'h0);
    chk("rst_pc_plus4", 64'(pc_plus4), 64'h0);
`ifdef IFU_PERF_CNT_EN
    chk("rst_flush_count", 64'(flush_count), 64'd0);
    chk("rst_drop_count", 64'(drop_count), 64'd0);
`endif
    reset = 1'b0;
  endtask

  task automatic end_test(input string name);
    chk({name, "_req_drained"}, 64'(exp_req.size()), 64'd0);
    chk({name, "_out_drained"}, 64'(exp_out.size()), 64'd0);
    exp_req.delete();
    exp_out.delete();
  endtask

  initial begin
    tests_run = 0;
    fails = 0;
    reset = 1'b1;
    instr_ready = 1'b0;
    zero_val = 1'b0;
    mem_wait = 0;
    init_mem();

    // T1: zero-wait streaming from reset
    do_reset();
    instr_ready = 1'b1;
    exp_req.push_back(32'h0); exp_req.push_back(32'h4);
    exp_req.push_back(32'h8); exp_req.push_back(32'hC);
    exp_out_push(0, 32'h4); exp_out_push(1, 32'h8); exp_out_push(2, 32'hC);
    cycles(1);
    chk("t1_valid_c1", 64'(instr_valid), 64'd0);
    chk("t1_req_c1", 64'(imem_req), 64'd1);
    cycles(1);
    chk("t1_valid_c2", 64'(instr_valid), 64'd1);
    cycles(3);
    end_test("t1");

    // T2: consumer stalled, FIFO fills, then a single pop
    do_reset();
    exp_req.push_back(32'h0); exp_req.push_back(32'h4); exp_req.push_back(32'h8);
    exp_out_push(0, 32'h4);
    cycles(2);
    for (int k = 0; k < 3; k++) begin
      cycles(1);
      chk("t2_req_full", 64'(imem_req), 64'd0);
    end
    instr_ready = 1'b1;
    cycles(1);
    instr_ready = 1'b0;
    chk("t2_req_resume", 64'(imem_req), 64'd1);
    chk("t2_addr_resume", 64'(imem_addr), 64'h8);
    cycles(1);
    chk("t2_req_refull", 64'(imem_req), 64'd0);
    cycles(1);
    end_test("t2");

    // T3: jump at pc 0 to 0x100 with a full FIFO
    init_mem();
    mem[0] = 32'h0800_0040;
    do_reset();
    exp_req.push_back(32'h0); exp_req.push_back(32'h4);
    exp_req.push_back(32'h100); exp_req.push_back(32'h104);
    exp_out_push(0, 32'h4); exp_out_push(64, 32'h104);
    cycles(3);
    chk("t3_req_full", 64'(imem_req), 64'd0);
    cycles(1);
    instr_ready = 1'b1;
    cycles(1);
    chk("t3_valid_flushed", 64'(instr_valid), 64'd0);
    chk("t3_req_target", 64'(imem_req), 64'd1);
    chk("t3_addr_target", 64'(imem_addr), 64'h100);
`ifdef IFU_PERF_CNT_EN
    chk("t3_flush_count", 64'(flush_count), 64'd1);
    chk("t3_drop_count", 64'(drop_count), 64'd0);
`endif
    cycles(2);
    end_test("t3");

    // T4: taken beq at 0x20 while fetch of 0x24 waits 3 cycles, then not taken
    init_mem();
    mem[8] = 32'h1000_FFFE;
    mem_wait = 3;
    zero_val = 1'b1;
    do_reset();
    instr_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      exp_req.push_back(32'(4 * i));
      exp_out_push(i, 32'(4 * i + 4));
    end
    exp_req.push_back(32'h24); exp_req.push_back(32'h1C);
    exp_req.push_back(32'h20); exp_req.push_back(32'h24);
    exp_out_push(7, 32'h20); exp_out_push(8, 32'h24); exp_out_push(9, 32'h28);
    cycles(38);
    zero_val = 1'b0;
    for (int k = 0; k < 2; k++) begin
      chk("t4_drop_req", 64'(imem_req), 64'd1);
      chk("t4_drop_addr", 64'(imem_addr), 64'h24);
      chk("t4_drop_valid", 64'(instr_valid), 64'd0);
      cycles(1);
    end
    cycles(1);
    chk("t4_target_addr", 64'(imem_addr), 64'h1C);
    cycles(9);
`ifdef IFU_PERF_CNT_EN
    chk("t4_flush_count", 64'(flush_count), 64'd1);
    chk("t4_drop_count", 64'(drop_count), 64'd1);
`endif
    cycles(4);
    end_test("t4");

    // T5: backward branch to 0xFFFFFFFC, fetch PC wraps to 0
    init_mem();
    mem[0] = 32'h1000_FFFE;
    mem_wait = 0;
    zero_val = 1'b1;
    do_reset();
    instr_ready = 1'b1;
    exp_req.push_back(32'h0); exp_req.push_back(32'h4); exp_req.push_back(32'hFFFF_FFFC);
    exp_req.push_back(32'h0); exp_req.push_back(32'h4);
    exp_out_push(0, 32'h4); exp_out_push(255, 32'h0); exp_out_push(0, 32'h4);
    cycles(3);
    zero_val = 1'b0;
    chk("t5_wrap_addr", 64'(imem_addr), 64'hFFFF_FFFC);
    chk("t5_wrap_valid", 64'(instr_valid), 64'd0);
    cycles(3);
    end_test("t5");

    // T6: asynchronous reset with a request in flight
    init_mem();
    mem_wait = 3;
    do_reset();
    exp_req.push_back(32'h0);
    cycles(6);
    chk("t6_pre_req", 64'(imem_req), 64'd1);
    chk("t6_pre_valid", 64'(instr_valid), 64'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("t6_async_req", 64'(imem_req), 64'd0);
    chk("t6_async_valid", 64'(instr_valid), 64'd0);
    end_test("t6a");
    mem_wait = 0;
    do_reset();
    exp_req.push_back(32'h0); exp_req.push_back(32'h4);
    cycles(1);
    chk("t6_first_req", 64'(imem_req), 64'd1);
    chk("t6_first_addr", 64'(imem_addr), 64'h0);
    cycles(4);
    end_test("t6b");

    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
